// File: rtl/vga_plot_arbiter_if.sv
// rtl/vga_plot_arbiter_if.sv - three pixel source channels plus the registered adapter plot port
interface vga_plot_arbiter_if;
  logic       valid_0, valid_1, valid_2;
  logic [7:0] x_0, x_1, x_2;
  logic [6:0] y_0, y_1, y_2;
  logic [2:0] color_0, color_1, color_2;
  logic       last_0;
  logic       ready_0, ready_1, ready_2;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] Color;
  logic       plot;

  modport master (
    output valid_0, valid_1, valid_2, x_0, x_1, x_2, y_0, y_1, y_2,
           color_0, color_1, color_2, last_0,
    input  ready_0, ready_1, ready_2, x, y, Color, plot
  );

  modport slave (
    input  valid_0, valid_1, valid_2, x_0, x_1, x_2, y_0, y_1, y_2,
           color_0, color_1, color_2, last_0,
    output ready_0, ready_1, ready_2, x, y, Color, plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - priority/round-robin arbiter for the VGA adapter plot port
module vga_plot_arbiter #(
  parameter int unsigned XMAX = 159,
  parameter int unsigned YMAX = 119
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 hold,
  vga_plot_arbiter_if.slave    bus,
  output logic                 busy,
  output logic [7:0]           drop_count
);
  localparam logic [7:0] X_LIM = 8'(XMAX);
  localparam logic [6:0] Y_LIM = 7'(YMAX);

  typedef enum logic {ARB, BURST0} state_t;

  state_t     state, state_nxt;
  logic       rr, rr_nxt;  // 0 selects channel 1 first, 1 selects channel 2 first
  logic       rdy_0, rdy_1, rdy_2;
  logic       xfer, in_range;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_c;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] c_q;
  logic       plot_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ARB;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    case (state)
      ARB:     if (rdy_0 && !bus.last_0) state_nxt = BURST0;
      BURST0:  if (rdy_0 && bus.last_0)  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
    if (rdy_1) rr_nxt = 1'b1;
    if (rdy_2) rr_nxt = 1'b0;
  end

  // Grants are gated by reset so no beat can transfer while reset_n is low.
  always_comb begin
    rdy_0 = 1'b0;
    rdy_1 = 1'b0;
    rdy_2 = 1'b0;
    if (reset_n && !hold) begin
      if (state == BURST0) begin
        rdy_0 = bus.valid_0;
      end else if (bus.valid_0) begin
        rdy_0 = 1'b1;
      end else if (!rr) begin
        if (bus.valid_1)      rdy_1 = 1'b1;
        else if (bus.valid_2) rdy_2 = 1'b1;
      end else begin
        if (bus.valid_2)      rdy_2 = 1'b1;
        else if (bus.valid_1) rdy_1 = 1'b1;
      end
    end
  end

  always_comb begin
    sel_x = bus.x_0;
    sel_y = bus.y_0;
    sel_c = bus.color_0;
    if (rdy_1) begin
      sel_x = bus.x_1;
      sel_y = bus.y_1;
      sel_c = bus.color_1;
    end else if (rdy_2) begin
      sel_x = bus.x_2;
      sel_y = bus.y_2;
      sel_c = bus.color_2;
    end
  end

  assign xfer     = rdy_0 | rdy_1 | rdy_2;
  assign in_range = (sel_x <= X_LIM) && (sel_y <= Y_LIM);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
      plot_q     <= 1'b0;
      drop_count <= '0;
    end else begin
      plot_q <= xfer && in_range;
      if (xfer && in_range) begin
        x_q <= sel_x;
        y_q <= sel_y;
        c_q <= sel_c;
      end
      if (xfer && !in_range && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  assign bus.ready_0 = rdy_0;
  assign bus.ready_1 = rdy_1;
  assign bus.ready_2 = rdy_2;
  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.Color   = c_q;
  assign bus.plot    = plot_q;
  assign busy        = (state == BURST0);
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - scoreboard bench for vga_plot_arbiter
module tb_vga_plot_arbiter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       hold;
  logic       busy;
  logic [7:0] drop_count;

  vga_plot_arbiter_if bus ();

  vga_plot_arbiter #(.XMAX(159), .YMAX(119)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hold       (hold),
    .bus        (bus),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int px, input int py, input int pc);
    exp_q.push_back({8'(px), 7'(py), 3'(pc)});
  endtask

  // Monitor: every plot strobe must match the oldest expected pixel.
  always @(negedge clk) begin
    if (bus.plot === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d, expected no plot", bus.x, bus.y, bus.Color);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({bus.x, bus.y, bus.Color} !== e) begin
          n_fail++;
          $display("FAIL plot_data: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   bus.x, bus.y, bus.Color, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.valid_0 = 0; bus.valid_1 = 0; bus.valid_2 = 0; bus.last_0 = 0;
    bus.x_0 = 0; bus.y_0 = 0; bus.color_0 = 0;
    bus.x_1 = 0; bus.y_1 = 0; bus.color_1 = 0;
    bus.x_2 = 0; bus.y_2 = 0; bus.color_2 = 0;
  endtask

  initial begin
    int c1, c2;
    idle_inputs();
    hold    = 0;
    reset_n = 0;
    step();
    bus.valid_1 = 1;
    #1;
    chk("reset_ready_1", bus.ready_1, 0);
    step();
    chk("reset_plot", bus.plot, 0);
    chk("reset_x", bus.x, 0);
    chk("reset_y", bus.y, 0);
    chk("reset_color", bus.Color, 0);
    chk("reset_busy", busy, 0);
    chk("reset_drop", drop_count, 0);
    bus.valid_1 = 0;
    reset_n = 1;
    step();

    // Single beats on channel 1 then channel 2.
    bus.valid_1 = 1; bus.x_1 = 10; bus.y_1 = 20; bus.color_1 = 3;
    #1;
    chk("single_ready_1", bus.ready_1, 1);
    chk("single_ready_2_idle", bus.ready_2, 0);
    push(10, 20, 3);
    step();
    bus.valid_1 = 0;
    bus.valid_2 = 1; bus.x_2 = 159; bus.y_2 = 119; bus.color_2 = 7;
    #1;
    chk("single_ready_2", bus.ready_2, 1);
    chk("single_plot_1", bus.plot, 1);
    push(159, 119, 7);
    step();
    bus.valid_2 = 0;
    chk("single_plot_2", bus.plot, 1);
    step();
    chk("single_plot_off", bus.plot, 0);

    // Round-robin alternation, data advances only after each channel's grant.
    c1 = 0; c2 = 0;
    bus.valid_1 = 1; bus.x_1 = 8'(c1); bus.y_1 = 1; bus.color_1 = 1;
    bus.valid_2 = 1; bus.x_2 = 8'(100 + c2); bus.y_2 = 2; bus.color_2 = 2;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready_1", bus.ready_1, (k % 2 == 0) ? 1 : 0);
      chk("rr_ready_2", bus.ready_2, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 0) push(c1, 1, 1); else push(100 + c2, 2, 2);
      step();
      chk("rr_plot", bus.plot, 1);
      if (k % 2 == 0) begin c1++; bus.x_1 = 8'(c1); end
      else begin c2++; bus.x_2 = 8'(100 + c2); end
    end

    // Channel 0 burst of 4 with channels 1 and 2 contending.
    for (int k = 0; k < 4; k++) begin
      bus.valid_0 = 1; bus.x_0 = 8'(k * 10); bus.y_0 = 5; bus.color_0 = 5;
      bus.last_0 = (k == 3);
      #1;
      chk("burst_ready_0", bus.ready_0, 1);
      chk("burst_ready_1", bus.ready_1, 0);
      chk("burst_ready_2", bus.ready_2, 0);
      chk("burst_busy_pre", busy, (k == 0) ? 0 : 1);
      push(k * 10, 5, 5);
      step();
    end
    bus.valid_0 = 0; bus.last_0 = 0;
    #1;
    chk("burst_busy_after", busy, 0);
    chk("burst_then_ready_1", bus.ready_1, 1);
    chk("burst_then_ready_2", bus.ready_2, 0);
    push(c1, 1, 1);
    step();
    bus.valid_1 = 0; bus.valid_2 = 0;
    step();

    // Out-of-range beats: no plot, position held, drop counter advances.
    bus.valid_1 = 1; bus.x_1 = 160; bus.y_1 = 0; bus.color_1 = 6;
    #1;
    chk("oob_ready_1", bus.ready_1, 1);
    step();
    bus.valid_1 = 0;
    chk("oob_plot_a", bus.plot, 0);
    chk("oob_drop_a", drop_count, 1);
    chk("oob_hold_x_a", bus.x, c1);
    chk("oob_hold_y_a", bus.y, 1);
    bus.valid_2 = 1; bus.x_2 = 0; bus.y_2 = 120; bus.color_2 = 6;
    step();
    bus.valid_2 = 0;
    chk("oob_plot_b", bus.plot, 0);
    chk("oob_drop_b", drop_count, 2);
    chk("oob_hold_x_b", bus.x, c1);
    chk("oob_hold_y_b", bus.y, 1);
    bus.valid_2 = 1; bus.x_2 = 200; bus.y_2 = 0;
    for (int k = 0; k < 300; k++) step();
    bus.valid_2 = 0;
    chk("oob_drop_sat", drop_count, 255);
    chk("oob_plot_sat", bus.plot, 0);
    step();

    // Hold mid-burst, then reset mid-burst.
    bus.valid_0 = 1; bus.x_0 = 1; bus.y_0 = 1; bus.color_0 = 1; bus.last_0 = 0;
    push(1, 1, 1);
    step();
    chk("hold_busy_start", busy, 1);
    hold = 1;
    bus.x_0 = 2; bus.y_0 = 2; bus.color_0 = 2;
    bus.valid_1 = 1; bus.x_1 = 40; bus.y_1 = 41; bus.color_1 = 4;
    bus.valid_2 = 1; bus.x_2 = 50; bus.y_2 = 51; bus.color_2 = 3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_ready_0", bus.ready_0, 0);
      chk("hold_ready_1", bus.ready_1, 0);
      chk("hold_ready_2", bus.ready_2, 0);
      step();
      chk("hold_busy", busy, 1);
      chk("hold_plot", bus.plot, 0);
    end
    hold = 0;
    #1;
    chk("hold_release_ready_0", bus.ready_0, 1);
    push(2, 2, 2);
    step();
    bus.x_0 = 3; bus.y_0 = 3; bus.color_0 = 3;
    reset_n = 0;
    #1;
    chk("rst_ready_0", bus.ready_0, 0);
    step();
    chk("rst_busy", busy, 0);
    chk("rst_plot", bus.plot, 0);
    chk("rst_drop", drop_count, 0);
    bus.valid_0 = 0;
    reset_n = 1;
    #1;
    chk("rst_rr_ready_1", bus.ready_1, 1);
    chk("rst_rr_ready_2", bus.ready_2, 0);
    push(40, 41, 4);
    step();
    idle_inputs();
    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
